// File: rtl/vc_fifo.sv
// Multi-virtual-channel input buffer: NUM_VC independent circular queues with one
// VC-steered push and one VC-steered pop per cycle, FWFT peek, credit return and sticky errors.
module vc_fifo #(
    parameter int WIDTH    = 16,
    parameter int DEPTH    = 5,
    parameter int NUM_VC   = 2,
    parameter int AF_LEVEL = 1,
    parameter int AE_LEVEL = 1,
    localparam int VC_W    = (NUM_VC > 1) ? $clog2(NUM_VC) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push_req,
    input  logic [VC_W-1:0]   push_vc,
    input  logic [WIDTH-1:0]  data_in,
    input  logic              pop_req,
    input  logic [VC_W-1:0]   pop_vc,
    output logic [WIDTH-1:0]  data_out,
    output logic [WIDTH-1:0]  peek_out,
    output logic [NUM_VC-1:0] full,
    output logic [NUM_VC-1:0] empty,
    output logic [NUM_VC-1:0] almost_full,
    output logic [NUM_VC-1:0] almost_empty,
    output logic              credit_valid,
    output logic [VC_W-1:0]   credit_vc,
    output logic [2:0]        error
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [VC_W:0]  NUM_VC_L   = (VC_W + 1)'(NUM_VC);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

    // NOTE: storage carries no reset; only pointers and counts define validity,
    // so clearing the array would cost a reset net on every bit for nothing.
    logic [WIDTH-1:0] mem_q [NUM_VC][DEPTH];

    logic [PTR_W-1:0] wr_ptr_q [NUM_VC];
    logic [PTR_W-1:0] wr_ptr_d [NUM_VC];
    logic [PTR_W-1:0] rd_ptr_q [NUM_VC];
    logic [PTR_W-1:0] rd_ptr_d [NUM_VC];
    logic [CNT_W-1:0] count_q  [NUM_VC];
    logic [CNT_W-1:0] count_d  [NUM_VC];

    logic [WIDTH-1:0] data_out_q, data_out_d;
    logic             credit_valid_q;
    logic [VC_W-1:0]  credit_vc_q, credit_vc_d;
    logic [2:0]       error_q, error_d;

    logic             push_vc_ok, pop_vc_ok;
    logic [VC_W-1:0]  push_idx, pop_idx;
    logic             push_ok, pop_ok;

    // Out-of-range indices are steered to VC0 so array reads stay in bounds;
    // the *_vc_ok qualifiers keep such requests from having any effect.
    assign push_vc_ok = ({1'b0, push_vc} < NUM_VC_L);
    assign pop_vc_ok  = ({1'b0, pop_vc}  < NUM_VC_L);
    assign push_idx   = push_vc_ok ? push_vc : '0;
    assign pop_idx    = pop_vc_ok  ? pop_vc  : '0;

    assign pop_ok  = pop_req && pop_vc_ok && !empty[pop_idx];
    assign push_ok = push_req && push_vc_ok &&
                     (!full[push_idx] || (pop_ok && (pop_vc == push_vc)));

    assign peek_out = mem_q[pop_idx][rd_ptr_q[pop_idx]];

    // NOTE: every always_comb output gets a default before any conditional
    // assignment, otherwise an untaken branch would infer a latch.
    always_comb begin
        full         = '0;
        empty        = '0;
        almost_full  = '0;
        almost_empty = '0;
        for (int v = 0; v < NUM_VC; v++) begin
            full[v]         = (count_q[v] == CNT_FULL);
            empty[v]        = (count_q[v] == '0);
            almost_full[v]  = ((DEPTH - int'(count_q[v])) <= AF_LEVEL);
            almost_empty[v] = (int'(count_q[v]) <= AE_LEVEL);
        end
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        for (int v = 0; v < NUM_VC; v++) begin
            if (push_ok && (push_idx == VC_W'(v))) begin
                wr_ptr_d[v] = (wr_ptr_q[v] == PTR_LAST) ? '0 : wr_ptr_q[v] + PTR_W'(1);
            end
            if (pop_ok && (pop_idx == VC_W'(v))) begin
                rd_ptr_d[v] = (rd_ptr_q[v] == PTR_LAST) ? '0 : rd_ptr_q[v] + PTR_W'(1);
            end
            case ({push_ok && (push_idx == VC_W'(v)), pop_ok && (pop_idx == VC_W'(v))})
                2'b10:   count_d[v] = count_q[v] + CNT_W'(1);
                2'b01:   count_d[v] = count_q[v] - CNT_W'(1);
                default: count_d[v] = count_q[v];
            endcase
        end
    end

    always_comb begin
        data_out_d  = pop_ok ? peek_out : data_out_q;
        credit_vc_d = pop_ok ? pop_vc   : credit_vc_q;
        error_d     = error_q;
        if (push_req && push_vc_ok && !push_ok)                error_d[0] = 1'b1;
        if (pop_req && pop_vc_ok && empty[pop_idx])            error_d[1] = 1'b1;
        if ((push_req && !push_vc_ok) || (pop_req && !pop_vc_ok)) error_d[2] = 1'b1;
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int v = 0; v < NUM_VC; v++) begin
                wr_ptr_q[v] <= '0;
                rd_ptr_q[v] <= '0;
                count_q[v]  <= '0;
            end
            data_out_q     <= '0;
            credit_valid_q <= 1'b0;
            credit_vc_q    <= '0;
            error_q        <= '0;
        end else begin
            wr_ptr_q       <= wr_ptr_d;
            rd_ptr_q       <= rd_ptr_d;
            count_q        <= count_d;
            data_out_q     <= data_out_d;
            credit_valid_q <= pop_ok;
            credit_vc_q    <= credit_vc_d;
            error_q        <= error_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[push_idx][wr_ptr_q[push_idx]] <= data_in;
        end
    end

    assign data_out     = data_out_q;
    assign credit_valid = credit_valid_q;
    assign credit_vc    = credit_vc_q;
    assign error        = error_q;

endmodule

// File: tb/tb_vc_fifo.sv
// Scoreboard bench for vc_fifo: a 2-VC instance driven against a queue model,
// plus a 3-VC instance for the illegal-index case.
module tb_vc_fifo;

    localparam int WIDTH = 16;
    localparam int DEPTH = 5;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             rst, push_req, pop_req;
    logic [0:0]       push_vc, pop_vc;
    logic [WIDTH-1:0] data_in, data_out, peek_out;
    logic [1:0]       full, empty, almost_full, almost_empty;
    logic             credit_valid;
    logic [0:0]       credit_vc;
    logic [2:0]       error;

    logic             rst3, push_req3, pop_req3;
    logic [1:0]       push_vc3, pop_vc3;
    logic [WIDTH-1:0] data_in3, data_out3, peek_out3;
    logic [2:0]       full3, empty3, almost_full3, almost_empty3;
    logic             credit_valid3;
    logic [1:0]       credit_vc3;
    logic [2:0]       error3;

    vc_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH), .NUM_VC(2)) u_dut (
        .clk(clk), .rst(rst), .push_req(push_req), .push_vc(push_vc), .data_in(data_in),
        .pop_req(pop_req), .pop_vc(pop_vc), .data_out(data_out), .peek_out(peek_out),
        .full(full), .empty(empty), .almost_full(almost_full), .almost_empty(almost_empty),
        .credit_valid(credit_valid), .credit_vc(credit_vc), .error(error)
    );

    vc_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH), .NUM_VC(3)) u_dut3 (
        .clk(clk), .rst(rst3), .push_req(push_req3), .push_vc(push_vc3), .data_in(data_in3),
        .pop_req(pop_req3), .pop_vc(pop_vc3), .data_out(data_out3), .peek_out(peek_out3),
        .full(full3), .empty(empty3), .almost_full(almost_full3), .almost_empty(almost_empty3),
        .credit_valid(credit_valid3), .credit_vc(credit_vc3), .error(error3)
    );

    int n_checks = 0;
    int n_fail   = 0;

    logic [WIDTH-1:0] mq [2][$];
    logic [WIDTH-1:0] exp_q [$];
    logic [WIDTH-1:0] last_dout;
    logic [2:0]       exp_err;

    task automatic model_clear();
        mq[0].delete();
        mq[1].delete();
        exp_q.delete();
        last_dout = '0;
        exp_err   = '0;
    endtask

    task automatic idle_inputs();
        push_req = 1'b0; push_vc = '0; data_in = '0; pop_req = 1'b0; pop_vc = '0;
    endtask

    // One clock of traffic on the 2-VC instance, with the model stepped alongside.
    task automatic do_cycle(input string tag, input logic ps, input logic [0:0] pvc,
                            input logic [WIDTH-1:0] din, input logic pp, input logic [0:0] ovc);
        logic             pop_ok, push_ok;
        logic [1:0]       exp_full, exp_empty, exp_af, exp_ae;
        push_req = ps; push_vc = pvc; data_in = din; pop_req = pp; pop_vc = ovc;
        #1;
        if (mq[ovc].size() > 0) begin
            n_checks++;
            if (peek_out !== mq[ovc][0]) begin
                n_fail++;
                $display("FAIL %s peek: got %h expected %h", tag, peek_out, mq[ovc][0]);
            end
        end
        pop_ok  = pp && (mq[ovc].size() > 0);
        push_ok = ps && ((mq[pvc].size() < DEPTH) || (pop_ok && (ovc == pvc)));
        if (pop_ok) exp_q.push_back(mq[ovc].pop_front());
        if (pp && !pop_ok) exp_err[1] = 1'b1;
        if (push_ok) mq[pvc].push_back(din);
        else if (ps) exp_err[0] = 1'b1;

        @(posedge clk);
        #1;
        idle_inputs();
        if (pop_ok && exp_q.size() > 0) last_dout = exp_q.pop_front();
        for (int v = 0; v < 2; v++) begin
            exp_full[v]  = (mq[v].size() == DEPTH);
            exp_empty[v] = (mq[v].size() == 0);
            exp_af[v]    = ((DEPTH - mq[v].size()) <= 1);
            exp_ae[v]    = (mq[v].size() <= 1);
        end
        n_checks++;
        if (data_out !== last_dout) begin
            n_fail++;
            $display("FAIL %s data_out: got %h expected %h", tag, data_out, last_dout);
        end
        n_checks++;
        if (credit_valid !== pop_ok) begin
            n_fail++;
            $display("FAIL %s credit_valid: got %b expected %b", tag, credit_valid, pop_ok);
        end
        if (pop_ok) begin
            n_checks++;
            if (credit_vc !== ovc) begin
                n_fail++;
                $display("FAIL %s credit_vc: got %0d expected %0d", tag, credit_vc, ovc);
            end
        end
        n_checks++;
        if (error !== exp_err) begin
            n_fail++;
            $display("FAIL %s error: got %b expected %b", tag, error, exp_err);
        end
        n_checks++;
        if ({full, empty, almost_full, almost_empty} !== {exp_full, exp_empty, exp_af, exp_ae}) begin
            n_fail++;
            $display("FAIL %s flags(full,empty,af,ae): got %b %b %b %b expected %b %b %b %b", tag,
                     full, empty, almost_full, almost_empty, exp_full, exp_empty, exp_af, exp_ae);
        end
    endtask

    task automatic check_reset_state(input string tag);
        n_checks++;
        if ({empty, full, almost_empty, almost_full} !== {2'b11, 2'b00, 2'b11, 2'b00}) begin
            n_fail++;
            $display("FAIL %s flags: got empty=%b full=%b ae=%b af=%b expected 11 00 11 00",
                     tag, empty, full, almost_empty, almost_full);
        end
        n_checks++;
        if ({data_out, error, credit_valid} !== {16'h0000, 3'b000, 1'b0}) begin
            n_fail++;
            $display("FAIL %s outputs: got data_out=%h error=%b credit_valid=%b expected 0 0 0",
                     tag, data_out, error, credit_valid);
        end
    endtask

    task automatic test_reset();
        idle_inputs();
        push_req3 = 1'b0; push_vc3 = '0; data_in3 = '0; pop_req3 = 1'b0; pop_vc3 = '0;
        rst = 1'b0; rst3 = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1; rst3 = 1'b1;
        model_clear();
        check_reset_state("reset");
    endtask

    task automatic test_fill_overflow();
        for (int i = 1; i <= DEPTH; i++) do_cycle("fill", 1'b1, 1'b1, WIDTH'(i), 1'b0, 1'b0);
        do_cycle("overflow", 1'b1, 1'b1, 16'h0006, 1'b0, 1'b0);
    endtask

    task automatic test_drain();
        for (int i = 0; i < DEPTH; i++) do_cycle("drain", 1'b0, 1'b0, '0, 1'b1, 1'b1);
    endtask

    task automatic test_push_pop_full();
        for (int i = 0; i < DEPTH; i++) do_cycle("refill", 1'b1, 1'b1, 16'h0021 + WIDTH'(i), 1'b0, 1'b0);
        do_cycle("pushpop_full", 1'b1, 1'b1, 16'h00AA, 1'b1, 1'b1);
        for (int i = 0; i < DEPTH; i++) do_cycle("drain_aa", 1'b0, 1'b0, '0, 1'b1, 1'b1);
    endtask

    task automatic test_empty_underflow();
        do_cycle("pushpop_empty", 1'b1, 1'b0, 16'h0033, 1'b1, 1'b0);
        do_cycle("pop_33", 1'b0, 1'b0, '0, 1'b1, 1'b0);
    endtask

    task automatic test_independent();
        do_cycle("indep_a", 1'b1, 1'b1, 16'h0044, 1'b0, 1'b0);
        do_cycle("indep_b", 1'b1, 1'b0, 16'h0055, 1'b1, 1'b1);
        do_cycle("indep_c", 1'b1, 1'b1, 16'h0066, 1'b1, 1'b0);
        do_cycle("indep_d", 1'b0, 1'b0, '0, 1'b1, 1'b1);
    endtask

    task automatic test_reset_mid();
        do_cycle("pre_rst", 1'b1, 1'b0, 16'h0077, 1'b0, 1'b0);
        push_req = 1'b1; push_vc = 1'b1; data_in = 16'h0088; pop_req = 1'b1; pop_vc = 1'b0;
        rst = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        idle_inputs();
        model_clear();
        check_reset_state("reset_mid");
    endtask

    task automatic test_bad_vc();
        push_req3 = 1'b1; push_vc3 = 2'd3; data_in3 = 16'h00BB;
        @(posedge clk);
        #1;
        push_req3 = 1'b0;
        n_checks++;
        if ({error3, empty3, full3} !== {3'b100, 3'b111, 3'b000}) begin
            n_fail++;
            $display("FAIL bad_vc: got error=%b empty=%b full=%b expected 100 111 000", error3, empty3, full3);
        end
        push_req3 = 1'b1; push_vc3 = 2'd2; data_in3 = 16'h00CC;
        @(posedge clk);
        #1;
        n_checks++;
        if (empty3 !== 3'b011) begin
            n_fail++;
            $display("FAIL vc2_push: got empty=%b expected 011", empty3);
        end
        data_in3 = 16'h00DD; pop_req3 = 1'b1; pop_vc3 = 2'd2;
        rst3 = 1'b0;
        @(posedge clk);
        #1;
        rst3 = 1'b1; push_req3 = 1'b0; pop_req3 = 1'b0;
        n_checks++;
        if ({empty3, error3, credit_valid3, data_out3} !== {3'b111, 3'b000, 1'b0, 16'h0000}) begin
            n_fail++;
            $display("FAIL reset3: got empty=%b error=%b credit=%b data_out=%h expected 111 000 0 0000",
                     empty3, error3, credit_valid3, data_out3);
        end
    endtask

    initial begin
        rst = 1'b1; rst3 = 1'b1;
        idle_inputs();
        push_req3 = 1'b0; push_vc3 = '0; data_in3 = '0; pop_req3 = 1'b0; pop_vc3 = '0;
        model_clear();
        @(posedge clk);
        #1;
        test_reset();
        test_fill_overflow();
        test_drain();
        test_push_pop_full();
        test_empty_underflow();
        test_independent();
        test_reset_mid();
        test_bad_vc();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
